// File: rtl/regfile_2w4r_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_2w4r_pkg
// Purpose : Shared constants and types for the 2-write / 4-read register
//           file and its write-select decoders.
// Contents: REG_ADDR_W, NUM_REGS, ZERO_REG, reg_addr_t
// Revision: 1.0 - initial release
// ============================================================================
package regfile_2w4r_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : regfile_2w4r_pkg
`default_nettype wire

// File: rtl/regfile_2w4r_decoder_32.sv
`default_nettype none
// ============================================================================
// Module  : decoder_32
// Purpose : 5-to-32 one-hot decoder used as a register write select.
//           Output bit 0 is never set, so r0 can never be selected.
// Ports   : i_addr   in  5   register address
//           o_onehot out 32  one-hot select (bit 0 always 0)
// Revision: 1.0 - initial release
// ============================================================================
module decoder_32
  import regfile_2w4r_pkg::*;
(
  input  reg_addr_t             i_addr,
  output logic [NUM_REGS-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_addr != ZERO_REG) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule : decoder_32
`default_nettype wire

// File: rtl/regfile_2w4r.sv
`default_nettype none
// ============================================================================
// Module  : regfile_2w4r
// Purpose : 32 x DATA_WIDTH architectural register file, two write lanes
//           (A older, B younger), four combinational read ports, r0 wired to
//           zero, plus a per-register pending-write scoreboard for issue.
// Ports   : clock, ctrl_reset_n (async, active-low)
//           ctrl_writeEnableA/B, ctrl_writeRegA/B, data_writeA/B  - writeback
//           ctrl_issueEnA/B, ctrl_issueRegA/B                      - issue
//           ctrl_readRegA0/A1/B0/B1 -> data_readRegA0/A1/B0/B1     - reads
//           pending                                                - scoreboard
// Options : REGFILE_BYPASS_EN - forward same-cycle write data to read ports
// Revision: 1.0 - initial release
// ============================================================================
module regfile_2w4r
  import regfile_2w4r_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  ctrl_reset_n,
  input  logic                  ctrl_writeEnableA,
  input  logic [4:0]            ctrl_writeRegA,
  input  logic [DATA_WIDTH-1:0] data_writeA,
  input  logic                  ctrl_writeEnableB,
  input  logic [4:0]            ctrl_writeRegB,
  input  logic [DATA_WIDTH-1:0] data_writeB,
  input  logic                  ctrl_issueEnA,
  input  logic [4:0]            ctrl_issueRegA,
  input  logic                  ctrl_issueEnB,
  input  logic [4:0]            ctrl_issueRegB,
  input  logic [4:0]            ctrl_readRegA0,
  input  logic [4:0]            ctrl_readRegA1,
  input  logic [4:0]            ctrl_readRegB0,
  input  logic [4:0]            ctrl_readRegB1,
  output logic [DATA_WIDTH-1:0] data_readRegA0,
  output logic [DATA_WIDTH-1:0] data_readRegA1,
  output logic [DATA_WIDTH-1:0] data_readRegB0,
  output logic [DATA_WIDTH-1:0] data_readRegB1,
  output logic [31:0]           pending
);

  localparam int NUM_RD = 4;

  // run_q stays low through reset and rises on the first edge after release,
  // so nothing presented on that release edge is captured.
  logic run_d, run_q;

  logic                  we_a, we_b, iss_a, iss_b;
  logic [NUM_REGS-1:0]   sel_a, sel_b;

  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_d, pending_q;

  reg_addr_t             rd_addr [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_data [NUM_RD];

  assign we_a  = ctrl_writeEnableA & run_q;
  assign we_b  = ctrl_writeEnableB & run_q;
  assign iss_a = ctrl_issueEnA     & run_q;
  assign iss_b = ctrl_issueEnB     & run_q;

  decoder_32 u_dec_a (
    .i_addr   (ctrl_writeRegA),
    .o_onehot (sel_a)
  );

  decoder_32 u_dec_b (
    .i_addr   (ctrl_writeRegB),
    .o_onehot (sel_b)
  );

  // Next-state: lane B applied after lane A so the younger write wins.
  always_comb begin
    run_d = 1'b1;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (we_a && sel_a[k]) regs_d[k] = data_writeA;
      if (we_b && sel_b[k]) regs_d[k] = data_writeB;
    end
    regs_d[0] = '0;
  end

  // Scoreboard: a new issue outranks a retiring write to the same register,
  // since the newer producer is still outstanding.
  always_comb begin
    pending_d = pending_q;
    for (int k = 1; k < NUM_REGS; k++) begin
      if ((iss_a && (ctrl_issueRegA == reg_addr_t'(k))) ||
          (iss_b && (ctrl_issueRegB == reg_addr_t'(k)))) begin
        pending_d[k] = 1'b1;
      end else if ((we_a && sel_a[k]) || (we_b && sel_b[k])) begin
        pending_d[k] = 1'b0;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      run_q     <= 1'b0;
      pending_q <= '0;
      regs_q[0] <= '0;
      for (int k = 1; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VALUE;
      end
    end else begin
      run_q     <= run_d;
      pending_q <= pending_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  assign pending = pending_q;

  assign rd_addr[0] = ctrl_readRegA0;
  assign rd_addr[1] = ctrl_readRegA1;
  assign rd_addr[2] = ctrl_readRegB0;
  assign rd_addr[3] = ctrl_readRegB1;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_read
    always_comb begin
      rd_data[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (we_a && (ctrl_writeRegA == rd_addr[p])) rd_data[p] = data_writeA;
      if (we_b && (ctrl_writeRegB == rd_addr[p])) rd_data[p] = data_writeB;
`endif
      // r0 overrides any forwarded value.
      if (rd_addr[p] == ZERO_REG) rd_data[p] = '0;
    end
  end

  assign data_readRegA0 = rd_data[0];
  assign data_readRegA1 = rd_data[1];
  assign data_readRegB0 = rd_data[2];
  assign data_readRegB1 = rd_data[3];

endmodule : regfile_2w4r
`default_nettype wire

// File: doc/regfile_2w4r.md
Name: regfile_2w4r

Overview:
- Architectural register file for the 2-wide pipeline: 32 x DATA_WIDTH registers, two write ports (lanes A and B), four read ports.
- Sits directly downstream of the write-enable decoder. Each write lane drives its own decoder_32 instance, whose one-hot output selects the register to update.
- Register r0 is hardwired to zero.
- Also holds a per-register pending scoreboard. Issue logic uses it to stall on registers with an outstanding write.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- RESET_VALUE, 0, value loaded into r1..r31 on reset.

Ports:
- clock  in  1  rising-edge clock.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- ctrl_writeEnableA  in  1  lane A writeback valid.
- ctrl_writeRegA  in  5  lane A destination register.
- data_writeA  in  DATA_WIDTH  lane A writeback data.
- ctrl_writeEnableB  in  1  lane B writeback valid (lane B is younger).
- ctrl_writeRegB  in  5  lane B destination register.
- data_writeB  in  DATA_WIDTH  lane B writeback data.
- ctrl_issueEnA  in  1  lane A issues an instruction with a destination.
- ctrl_issueRegA  in  5  lane A issue destination.
- ctrl_issueEnB  in  1  lane B issue valid.
- ctrl_issueRegB  in  5  lane B issue destination.
- ctrl_readRegA0/A1/B0/B1  in  5 each  read addresses.
- data_readRegA0/A1/B0/B1  out  DATA_WIDTH each  read data.
- pending  out  32  per-register outstanding-write bits; bit 0 is always 0.

Behaviour:
- Reset: ctrl_reset_n low asynchronously sets r1..r31 to RESET_VALUE and pending to 0.
  - Writes and issues in a cycle where reset is asserted are dropped.
  - Reset is released synchronously to the next rising edge (no capture on the release edge itself).
- Write: on the rising edge, register k loads lane data when that lane's writeEnable is 1 and its decoder_32 output bit k is 1.
  - decoder_32 bit 0 is 0, so writes to r0 are ignored.
- Write collision: A and B enabled with the same nonzero register → B data is stored. A is discarded.
- Read: combinational, zero latency from the stored array. Reading r0 always returns 0.
- Pending scoreboard, per nonzero register k, evaluated at the rising edge:
  - Set if an issue targets k (ctrl_issueEnA with ctrl_issueRegA == k, or the same for lane B).
  - Else clear if a write targets k (either lane).
  - Else hold.
  - Same-cycle set and clear on one register → set wins, because the newer producer is outstanding.
  - Issue to r0 is ignored.
- Both issue lanes naming the same register → single set, no error.
- Write to a non-pending register → stored normally. pending stays 0.
- Outputs are registered state or pure combinational reads. There are no handshakes and no backpressure.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding for each read port.
  - If the read address equals an enabled, nonzero write address in the same cycle, the output returns that write's data instead of the array value.
  - Both lanes match → data_writeB is returned.
  - r0 reads still return 0.
- Undefined: reads return array contents only. Same-cycle writes become visible after the edge, and the pipeline must cover the hazard with a stall.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5 and NUM_REGS = 32.
  - ZERO_REG = 5'd0.
  - A typedef for the register address.
- Sub-modules:
  - Instantiate the existing decoder_32 twice, once per write lane, for the one-hot write selects.
  - No other sub-module. Read muxes and bypass compare stay inline.

Test Plan:
- Reset, then read all 32 registers on all four ports → every data_read* = 0, pending = 0.
- Write A r5 = 0xDEADBEEF, next cycle read A0 = r5 → 0xDEADBEEF. Write A r0 = 0x1234, then read r0 → 0.
- Same cycle: A writes r7 = 0x11111111 and B writes r7 = 0x22222222, then read r7 → 0x22222222.
- Issue A r9 → pending[9] = 1 after the edge. Later, in one cycle, write A r9 = 0x5 and issue B r9 → pending[9] remains 1 and r9 = 0x5. Next cycle, write r9 with no issue → pending[9] = 0.
- REGFILE_BYPASS_EN defined: write B r3 = 0xCAFE while reading B1 = r3 in the same cycle → 0xCAFE before the edge. Macro undefined → previous r3 value before the edge, 0xCAFE after.
- Write r12 = 0xAAAA, then assert ctrl_reset_n low mid-cycle → r12 reads 0 immediately (asynchronous), and any write presented while reset is low is not stored.
